sram_bus_arbiter: RTL and testbench



---
 rtl/sram_bus_arbiter_pkg.sv | 23 ++
 rtl/sram_bus_arbiter_grant.sv | 48 ++++
 rtl/sram_bus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the SRAM bus arbiter: FSM state encoding, owner
// encoding and the downstream transfer-size constants.
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_bus_arbiter_grant.sv
// ---------------------------------------------------------------------------
// arb_grant
// Combinational winner selection between the instruction and data
// requesters. All arbitration-policy differences live here.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   undefined : data always beats instruction on a simultaneous request
//   defined   : on a simultaneous request the requester that did not win
//               the previous grant (last_owner) wins
//
// Ports:
//   inst_req    in   instruction requester is asking for the bus
//   data_req    in   data requester is asking for the bus
//   last_owner  in   owner of the previous grant (round-robin build only)
//   grant_valid out  at least one requester is asking
//   grant_owner out  which requester wins if a grant is taken now
// ---------------------------------------------------------------------------
module arb_grant
  import arb_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_owner_t last_owner,
`endif
  output logic       grant_valid,
  output arb_owner_t grant_owner
);

  // Pick the winner. A lone request always wins; only a collision consults
  // the policy. Defaults first so every path assigns both outputs.
  always_comb begin
    grant_valid = inst_req | data_req;
    grant_owner = OWN_INST;
`ifdef ARB_ROUND_ROBIN_EN
    if (inst_req && data_req) begin
      grant_owner = (last_owner == OWN_DATA) ? OWN_INST : OWN_DATA;
    end else if (data_req) begin
      grant_owner = OWN_DATA;
    end
`else
    if (data_req) begin
      grant_owner = OWN_DATA;
    end
`endif
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter
// Shares one SRAM-like downstream bus between the instruction-fetch and the
// data-cache requesters. At most one transaction is outstanding; the winning
// request is latched and the handshake/read data is routed back to its owner
// only. Optional macro ARB_ROUND_ROBIN_EN switches the collision policy from
// fixed data priority to alternating (see arb_grant).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   inst_req/inst_addr            instruction request (always word read)
//   inst_rdata/addr_ok/data_ok    instruction responses
//   data_req/wr/size/addr/wdata   data request
//   data_rdata/addr_ok/data_ok    data responses
//   bus_req/wr/size/addr/wdata    downstream request (from registers)
//   bus_rdata/addr_ok/data_ok     downstream responses
// ---------------------------------------------------------------------------
module sram_bus_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              grant_valid;
  arb_owner_t        grant_owner;
  logic              take_grant;
  logic              addr_evt;
  logic              done_evt;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t        last_owner_q;
`endif

  arb_grant u_grant (
    .inst_req    (inst_req),
    .data_req    (data_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_owner  (last_owner_q),
`endif
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Requests are only sampled in IDLE, which also guarantees one idle cycle
  // between consecutive transactions.
  assign take_grant = (state_q == IDLE) && grant_valid;

  // State register. Reset drops straight back to IDLE; any downstream
  // transaction in flight is abandoned (the bridge shares this reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winner's request at grant time so the bus fields stay stable
  // for the whole ADDR phase regardless of what the requesters do next.
  // Instruction fetches are always word reads with no write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_INST;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take_grant) begin
      owner_q <= grant_owner;
      if (grant_owner == OWN_DATA) begin
        wr_q    <= data_wr;
        size_q  <= data_size;
        addr_q  <= data_addr;
        wdata_q <= data_wdata;
      end else begin
        wr_q    <= 1'b0;
        size_q  <= SZ_WORD;
        addr_q  <= inst_addr;
        wdata_q <= '0;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who won last so a future collision goes to the other side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_q <= OWN_INST;
    end else if (take_grant) begin
      last_owner_q <= grant_owner;
    end
  end
`endif

  // Next state and all outputs. Handshakes are combinational from the bus
  // so the owner sees addr_ok/data_ok in the same cycle as the bridge
  // raises them. Responses arriving in the wrong state are simply ignored,
  // and a bus that answers addr_ok and data_ok together finishes in ADDR.
  always_comb begin
    state_d      = state_q;
    addr_evt     = 1'b0;
    done_evt     = 1'b0;
    bus_req      = 1'b0;
    bus_wr       = wr_q;
    bus_size     = size_q;
    bus_addr     = addr_q;
    bus_wdata    = wdata_q;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        bus_req = 1'b1;
        if (bus_addr_ok) begin
          addr_evt = 1'b1;
          if (bus_data_ok) begin
            done_evt = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          done_evt = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (owner_q == OWN_DATA) begin
      data_addr_ok = addr_evt;
      data_data_ok = done_evt;
      data_rdata   = done_evt ? bus_rdata : '0;
    end else begin
      inst_addr_ok = addr_evt;
      inst_data_ok = done_evt;
      inst_rdata   = done_evt ? bus_rdata : '0;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_arbiter
// Directed bench for sram_bus_arbiter. Each transaction pushes its expected
// per-cycle events (bus start, addr_ok, data_ok with rdata) into a queue; a
// monitor on the falling edge pops and compares whenever the DUT shows any
// event. A small bus-slave model answers with programmable wait states.
// ---------------------------------------------------------------------------
module tb_sram_bus_arbiter;
  import arb_pkg::*;

  typedef struct {
    int          cyc;
    logic        start;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [1:0]  size;
    logic        i_aok;
    logic        i_dok;
    logic        d_aok;
    logic        d_dok;
    logic [31:0] i_rd;
    logic [31:0] d_rd;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_addr_ok, bus_data_ok;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  rec_t sb[$];

  int          aok_delay = 0;
  int          dok_delay = 0;
  logic [31:0] rdata_val = '0;
  int          stray_dok = 0;
  bit          stray_aok = 1'b0;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok)
  );

  // Free-running clock and a cycle counter; cycle N is the interval after
  // the N-th rising edge.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Safety net in case something stalls forever.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Merge events that land in the same cycle into one record.
  task automatic pushRec(input rec_t r);
    rec_t m;
    if (sb.size() > 0 && sb[sb.size()-1].cyc == r.cyc) begin
      m = sb[sb.size()-1];
      if (r.start) begin
        m.start = 1'b1; m.addr = r.addr; m.wdata = r.wdata; m.wr = r.wr; m.size = r.size;
      end
      m.i_aok = m.i_aok | r.i_aok;
      m.d_aok = m.d_aok | r.d_aok;
      if (r.i_dok) begin m.i_dok = 1'b1; m.i_rd = r.i_rd; end
      if (r.d_dok) begin m.d_dok = 1'b1; m.d_rd = r.d_rd; end
      sb[sb.size()-1] = m;
    end else begin
      sb.push_back(r);
    end
  endtask

  // Expected events of one transaction whose bus phase starts at 'start'.
  task automatic pushTxn(input bit own_data, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int start,
                         input int aok_d, input int dok_d, output int done);
    rec_t r;
    r = '{default: '0};
    r.cyc = start; r.start = 1'b1; r.addr = addr; r.wr = wr; r.size = size; r.wdata = wdata;
    pushRec(r);
    r = '{default: '0};
    r.cyc = start + aok_d;
    if (own_data) r.d_aok = 1'b1; else r.i_aok = 1'b1;
    pushRec(r);
    r = '{default: '0};
    r.cyc = start + aok_d + dok_d;
    if (own_data) begin r.d_dok = 1'b1; r.d_rd = rdata; end
    else begin r.i_dok = 1'b1; r.i_rd = rdata; end
    pushRec(r);
    done = start + aok_d + dok_d;
  endtask

  // Requester behaviour: raise now, hold until addr_ok, drop next cycle.
  task automatic driveInst(input logic [31:0] addr);
    bit got = 1'b0;
    inst_req = 1'b1; inst_addr = addr;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (inst_addr_ok) got = 1'b1;
    end
    checkOutput("inst_aok_seen", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    inst_req = 1'b0;
  endtask

  task automatic driveData(input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bit got = 1'b0;
    data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (data_addr_ok) got = 1'b1;
    end
    checkOutput("data_aok_seen", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    data_req = 1'b0;
  endtask

  // One lone transaction from either requester; returns in the idle cycle
  // after completion.
  task automatic applyStimulus(input bit is_data, input logic wr, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int aok_d, input int dok_d);
    int done;
    @(posedge clk); #1;
    aok_delay = aok_d; dok_delay = dok_d; rdata_val = rdata;
    if (is_data) begin
      pushTxn(1'b1, wr, size, addr, wdata, rdata, cyc + 1, aok_d, dok_d, done);
      driveData(wr, size, addr, wdata);
    end else begin
      pushTxn(1'b0, 1'b0, SZ_WORD, addr, 32'd0, rdata, cyc + 1, aok_d, dok_d, done);
      driveInst(addr);
    end
    while (cyc < done + 1) begin @(posedge clk); #1; end
  endtask

  // Both requesters rise in the same cycle; the loser starts two cycles
  // after the winner completes.
  task automatic applyPair(input bit inst_first, input logic wr, input logic [1:0] size,
                           input logic [31:0] daddr, input logic [31:0] wdata,
                           input logic [31:0] iaddr, input logic [31:0] rdata,
                           input int aok_d, input int dok_d);
    int d1, d2;
    @(posedge clk); #1;
    aok_delay = aok_d; dok_delay = dok_d; rdata_val = rdata;
    if (inst_first) begin
      pushTxn(1'b0, 1'b0, SZ_WORD, iaddr, 32'd0, rdata, cyc + 1, aok_d, dok_d, d1);
      pushTxn(1'b1, wr, size, daddr, wdata, rdata, d1 + 2, aok_d, dok_d, d2);
    end else begin
      pushTxn(1'b1, wr, size, daddr, wdata, rdata, cyc + 1, aok_d, dok_d, d1);
      pushTxn(1'b0, 1'b0, SZ_WORD, iaddr, 32'd0, rdata, d1 + 2, aok_d, dok_d, d2);
    end
    fork
      driveInst(iaddr);
      driveData(wr, size, daddr, wdata);
    join
    while (cyc < d2 + 1) begin @(posedge clk); #1; end
  endtask

  // Bus slave model: counts wait states from the first ADDR cycle, can also
  // inject stray responses in IDLE and DATA.
  initial begin
    int phase = 0;
    int cnt = 0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
      if (rst) begin
        phase = 0;
      end else begin
        if (phase == 0 && bus_req) begin phase = 1; cnt = 0; end
        case (phase)
          1: begin
            if (cnt == aok_delay) begin
              bus_addr_ok = 1'b1;
              if (dok_delay == 0) begin
                bus_data_ok = 1'b1; bus_rdata = rdata_val; phase = 0;
              end else begin
                phase = 2; cnt = 0;
              end
            end else begin
              cnt++;
            end
          end
          2: begin
            cnt++;
            if (cnt == dok_delay) begin
              bus_data_ok = 1'b1; bus_rdata = rdata_val; phase = 0;
            end else if (stray_aok) begin
              bus_addr_ok = 1'b1;
            end
          end
          default: begin
            if (stray_dok > 0) begin
              bus_data_ok = 1'b1; bus_rdata = 32'h12345678; stray_dok--;
            end
          end
        endcase
      end
    end
  end

  // Monitor: on every falling edge outside reset, pop the expected record
  // whenever the DUT shows an event, check rdata is zero except on its
  // owner's completion, and check the bus fields through the ADDR phase.
  initial begin
    logic prev_req = 1'b0;
    rec_t cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
      end else begin
        logic start_now, ev;
        rec_t e;
        e = '{default: '0};
        start_now = bus_req && !prev_req;
        ev = start_now | inst_addr_ok | inst_data_ok | data_addr_ok | data_data_ok;
        if (ev) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL unexpected_event: got event at cycle %0d expected none", cyc);
          end else begin
            e = sb.pop_front();
            checkOutput("event_cycle", cyc, e.cyc);
            checkOutput("bus_start", {31'd0, start_now}, {31'd0, e.start});
            checkOutput("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, e.i_aok});
            checkOutput("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, e.i_dok});
            checkOutput("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, e.d_aok});
            checkOutput("data_data_ok", {31'd0, data_data_ok}, {31'd0, e.d_dok});
            if (e.start) cur = e;
          end
        end
        checkOutput("inst_rdata", inst_rdata, e.i_dok ? e.i_rd : 32'd0);
        checkOutput("data_rdata", data_rdata, e.d_dok ? e.d_rd : 32'd0);
        if (bus_req) begin
          checkOutput("bus_addr", bus_addr, cur.addr);
          checkOutput("bus_wr", {31'd0, bus_wr}, {31'd0, cur.wr});
          checkOutput("bus_size", {30'd0, bus_size}, {30'd0, cur.size});
          if (cur.wr) checkOutput("bus_wdata", bus_wdata, cur.wdata);
        end
        prev_req = bus_req;
      end
    end
  end

  // Directed sequence.
  initial begin
    int r;
    int done;

    // Outputs while held in reset.
    #12;
    checkOutput("rst_bus_req", {31'd0, bus_req}, 32'd0);
    checkOutput("rst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
    checkOutput("rst_inst_rdata", inst_rdata, 32'd0);
    checkOutput("rst_data_rdata", data_rdata, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    $display("[TB] single instruction read");
    applyStimulus(1'b0, 1'b0, SZ_WORD, 32'hBFC00000, 32'd0, 32'h3C1D8000, 1, 2);

    $display("[TB] simultaneous requests, data wins");
    applyPair(1'b0, 1'b1, SZ_WORD, 32'h80001000, 32'hDEADBEEF, 32'hBFC00004, 32'h24080001, 1, 2);

    $display("[TB] zero-wait slave");
    applyStimulus(1'b0, 1'b0, SZ_WORD, 32'hBFC00008, 32'd0, 32'h8C090000, 0, 0);

    $display("[TB] stray responses");
    stray_dok = 2;
    repeat (4) @(posedge clk);
    #1;
    stray_aok = 1'b1;
    applyStimulus(1'b1, 1'b0, SZ_WORD, 32'h80002000, 32'd0, 32'hCAFEF00D, 1, 3);
    stray_aok = 1'b0;

    $display("[TB] reset in DATA");
    @(posedge clk); #1;
    r = cyc;
    aok_delay = 0; dok_delay = 3; rdata_val = 32'h0BADF00D;
    pushTxn(1'b1, 1'b0, SZ_WORD, 32'h80000040, 32'd0, 32'h0BADF00D, r + 1, 0, 3, done);
    driveData(1'b0, SZ_WORD, 32'h80000040, 32'd0);
    while (cyc < r + 4) begin @(posedge clk); #1; end
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_bus_req", {31'd0, bus_req}, 32'd0);
    checkOutput("arst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
    checkOutput("arst_inst_rdata", inst_rdata, 32'd0);
    checkOutput("arst_data_rdata", data_rdata, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    $display("[TB] data read after reset");
    applyStimulus(1'b1, 1'b0, SZ_WORD, 32'h80000010, 32'd0, 32'h11223344, 2, 1);

    $display("[TB] byte write");
    applyStimulus(1'b1, 1'b1, SZ_BYTE, 32'h80000003, 32'h000000AB, 32'd0, 3, 1);

    $display("[TB] second simultaneous pair");
`ifdef ARB_ROUND_ROBIN_EN
    applyPair(1'b1, 1'b0, SZ_WORD, 32'h80003000, 32'd0, 32'hBFC0000C, 32'h55AA55AA, 1, 1);
`else
    applyPair(1'b0, 1'b0, SZ_WORD, 32'h80003000, 32'd0, 32'hBFC0000C, 32'h55AA55AA, 1, 1);
`endif

    repeat (5) @(posedge clk);
    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
